// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit frame sequencer,
// frame checking, scan-code FIFO, sticky error flags and a level interrupt.
module ps2_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  input  logic                          rd_en_i,
  input  logic                          clr_err_i,
  input  logic                          irq_en_i,
  output logic [7:0]                    dat_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          ovf_o,
  output logic                          irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DepthV = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  // Synchroniser and edge-detect state
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fe;
  logic w_bit;

  // Frame sequencer state
  state_e        r_state, w_state_d;
  logic [2:0]    r_bit_cnt, w_bit_cnt_d;
  logic [7:0]    r_shift, w_shift_d;
  logic          r_par, w_par_d;
  logic [TW-1:0] r_to_cnt, w_to_cnt_d;
  logic          w_push;
  logic          w_perr_set;
  logic          w_ferr_set;

  // FIFO state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [AW:0]   w_cnt;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf_set;

  // Flags and interrupt
  logic r_perr, r_ferr, r_ovf, r_irq;

  // Two-flop synchronisers on both pins plus one delay stage for edge detection.
  // They idle high so reset never looks like a falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_i;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat_i;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fe  = r_clk_prev & ~r_clk_s2;
  assign w_bit = r_dat_s2;

  // Sequencer state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_par     <= w_par_d;
      r_to_cnt  <= w_to_cnt_d;
    end
  end

  // Next-state: frame on PS/2 falling edges, abort a stalled frame on timeout
  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_par_d     = r_par;
    w_to_cnt_d  = r_to_cnt;
    w_push      = 1'b0;
    w_perr_set  = 1'b0;
    w_ferr_set  = 1'b0;

    if (!en_i) begin
      w_state_d   = StIdle;
      w_bit_cnt_d = 3'd0;
      w_to_cnt_d  = '0;
    end else if (w_fe) begin
      w_to_cnt_d = '0;
      unique case (r_state)
        StIdle: begin
          // A high bit here is a glitch, not a start bit
          if (!w_bit) begin
            w_state_d   = StData;
            w_bit_cnt_d = 3'd0;
            w_shift_d   = 8'd0;
          end
        end
        StData: begin
          w_shift_d[r_bit_cnt] = w_bit;
          w_bit_cnt_d          = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_d = StParity;
          end
        end
        StParity: begin
          w_par_d   = w_bit;
          w_state_d = StStop;
        end
        StStop: begin
          w_state_d   = StIdle;
          w_bit_cnt_d = 3'd0;
          // A bad stop bit masks a parity error
          if (!w_bit) begin
            w_ferr_set = 1'b1;
          end else if (^{r_shift, r_par} != 1'b1) begin
            w_perr_set = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end else if (r_state == StIdle) begin
      w_to_cnt_d = '0;
    end else if (r_to_cnt == ToLast) begin
      w_state_d   = StIdle;
      w_bit_cnt_d = 3'd0;
      w_to_cnt_d  = '0;
      w_ferr_set  = 1'b1;
    end else begin
      w_to_cnt_d = r_to_cnt + TW'(1);
    end
  end

  // FIFO status; pointers carry an extra wrap bit so full and empty differ
  assign w_cnt     = r_wptr - r_rptr;
  assign w_valid   = (r_wptr != r_rptr);
  assign w_full    = (w_cnt == DepthV);
  assign w_pop     = rd_en_i & w_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // FIFO pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + (AW + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW + 1)'(1);
      end
    end
  end

  // FIFO storage; contents are only visible while valid, so no reset needed
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

  // Sticky error flags; a new error outranks a clear in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_perr_set) begin
        r_perr <= 1'b1;
      end else if (clr_err_i) begin
        r_perr <= 1'b0;
      end
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (clr_err_i) begin
        r_ferr <= 1'b0;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_err_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Level interrupt, registered from the current status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= irq_en_i & (w_valid | r_perr | r_ferr | r_ovf);
    end
  end

  assign dat_o   = w_valid ? r_mem[r_rptr[AW-1:0]] : 8'd0;
  assign valid_o = w_valid;
  assign cnt_o   = w_cnt;
  assign perr_o  = r_perr;
  assign ferr_o  = r_ferr;
  assign ovf_o   = r_ovf;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: frame-level stimulus, queue reference
// model and a monitor that checks every byte the DUT hands out.
module tb_ps2_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst, en, ps2_clk, ps2_dat, rd_mon, rd_force, rd_en, clr_err, irq_en;
  logic [7:0] dat_o;
  logic       valid_o, perr_o, ferr_o, ovf_o, irq_o;
  logic [3:0] cnt_o;

  assign rd_en = rd_mon | rd_force;

  ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .rd_en_i(rd_en), .clr_err_i(clr_err), .irq_en_i(irq_en), .dat_o(dat_o),
    .valid_o(valid_o), .cnt_o(cnt_o), .perr_o(perr_o), .ferr_o(ferr_o),
    .ovf_o(ovf_o), .irq_o(irq_o)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  byte unsigned model_q[$];
  bit exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  bit drain = 0;
  int pop_req = 0, pop_done = 0;
  byte unsigned mon_exp;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a frame yields exactly one outcome, stop error dominating parity error
  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stop);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(par);
    if (!stop) exp_ferr = 1;
    else if (ones % 2 == 0) exp_perr = 1;
    else if (model_q.size() >= DEPTH) exp_ovf = 1;
    else model_q.push_back(d);
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Monitor: every byte taken from the DUT is compared with the scoreboard head
  initial begin
    rd_mon = 1'b0;
    forever begin
      @(negedge clk);
      if ((drain || pop_req > pop_done) && valid_o === 1'b1) begin
        if (model_q.size() == 0) begin
          chk("unexpected_byte", int'(dat_o), -1);
        end else begin
          mon_exp = model_q.pop_front();
          chk("pop_data", int'(dat_o), int'(mon_exp));
        end
        if (pop_req > pop_done) pop_done++;
        rd_mon = 1'b1;
      end else begin
        rd_mon = 1'b0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of a frame; optionally pops in the exact push cycle
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit pop_at_stop);
    logic [10:0]  b;
    byte unsigned e;
    b = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = b[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) begin
        if (pop_at_stop) e = model_q.pop_front();
        if (en) model_frame(d, par, stop);
      end
      if (i == 10 && pop_at_stop) begin
        // Falling edge reaches the sequencer on the third rising clk edge
        wait_cyc(2);
        chk("head_at_push", int'(dat_o), int'(e));
        rd_force = 1'b1;
        wait_cyc(1);
        rd_force = 1'b0;
        wait_cyc(HALF - 3);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    exp_perr = 0;
    exp_ferr = 0;
    exp_ovf  = 0;
    wait_cyc(1);
  endtask

  task automatic pop_n(input int n);
    pop_req += n;
    wait_cyc(n + 4);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    int         r;
    rst = 1'b1; en = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    rd_force = 1'b0; clr_err = 1'b0; irq_en = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);

    chk("rst_valid", int'(valid_o), 0);
    chk("rst_cnt", int'(cnt_o), 0);
    chk("rst_dat", int'(dat_o), 0);
    chk("rst_perr", int'(perr_o), 0);
    chk("rst_ferr", int'(ferr_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    chk("rst_irq", int'(irq_o), 0);

    // Single good frame, then pop
    irq_en = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 0);
    chk("t1_valid", int'(valid_o), 1);
    chk("t1_dat", int'(dat_o), 'h1C);
    chk("t1_cnt", int'(cnt_o), 1);
    chk("t1_irq", int'(irq_o), 1);
    pop_n(1);
    chk("t1_valid_after_pop", int'(valid_o), 0);
    chk("t1_cnt_after_pop", int'(cnt_o), 0);
    chk("t1_irq_after_pop", int'(irq_o), 0);

    // Parity error, clear, framing error
    send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
    chk("t2_perr", int'(perr_o), int'(exp_perr));
    chk("t2_cnt", int'(cnt_o), 0);
    clear_errs();
    chk("t2_perr_clr", int'(perr_o), 0);
    send_frame(8'h1C, 1'b1, 1'b0, 11, 0);
    chk("t2_ferr", int'(ferr_o), int'(exp_ferr));
    chk("t2_perr_masked", int'(perr_o), int'(exp_perr));
    chk("t2_cnt_nopush", int'(cnt_o), 0);
    clear_errs();

    // Overflow: nine frames into eight slots
    for (int k = 1; k <= 9; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 11, 0);
    chk("t3_cnt", int'(cnt_o), DEPTH);
    chk("t3_ovf", int'(ovf_o), int'(exp_ovf));
    chk("t3_head", int'(dat_o), 'h01);
    pop_n(8);
    chk("t3_empty", int'(valid_o), 0);
    chk("t3_model_empty", model_q.size(), 0);
    clear_errs();

    // Full FIFO with a pop coinciding with the ninth push
    for (int k = 1; k <= 8; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 11, 0);
    send_frame(8'h09, odd_par(8'h09), 1'b1, 11, 1);
    chk("t4_cnt", int'(cnt_o), DEPTH);
    chk("t4_ovf", int'(ovf_o), 0);
    chk("t4_head", int'(dat_o), 'h02);
    drain = 1;
    wait_cyc(20);
    drain = 0;
    chk("t4_drained", int'(valid_o), 0);
    chk("t4_model_empty", model_q.size(), 0);

    // Timeout on a partial frame, then recovery
    send_frame(8'h05, 1'b0, 1'b1, 4, 0);
    wait_cyc(TO + 10);
    exp_ferr = 1;
    chk("t5_ferr", int'(ferr_o), 1);
    chk("t5_cnt", int'(cnt_o), 0);
    clear_errs();
    send_frame(8'hF0, 1'b1, 1'b1, 11, 0);
    chk("t5_dat", int'(dat_o), 'hF0);
    chk("t5_cnt_after", int'(cnt_o), 1);
    pop_n(1);

    // Reset in the middle of a frame with data and an error pending
    send_frame(8'h33, odd_par(8'h33), 1'b1, 11, 0);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 6, 0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    model_q.delete();
    exp_perr = 0; exp_ferr = 0; exp_ovf = 0;
    wait_cyc(1);
    chk("t6_valid", int'(valid_o), 0);
    chk("t6_cnt", int'(cnt_o), 0);
    chk("t6_perr", int'(perr_o), 0);
    chk("t6_irq", int'(irq_o), 0);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 0);
    chk("t6_cnt_after", int'(cnt_o), 1);
    chk("t6_dat_after", int'(dat_o), 'h5A);
    pop_n(1);

    // Pop on an empty FIFO is ignored
    rd_force = 1'b1;
    wait_cyc(1);
    rd_force = 1'b0;
    wait_cyc(1);
    chk("t7_cnt", int'(cnt_o), 0);
    chk("t7_valid", int'(valid_o), 0);

    // Receiver disabled: frames are ignored entirely
    en = 1'b0;
    send_frame(8'h77, odd_par(8'h77), 1'b1, 11, 0);
    chk("t8_cnt", int'(cnt_o), 0);
    chk("t8_ferr", int'(ferr_o), 0);
    en = 1'b1;

    // Randomised frames with occasional parity/stop errors, drained continuously
    drain = 1;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      r = int'($urandom_range(0, 7));
      p = odd_par(d);
      s = 1'b1;
      if (r == 0) s = 1'b0;
      else if (r == 1) p = ~p;
      send_frame(d, p, s, 11, 0);
    end
    wait_cyc(10);
    drain = 0;
    chk("t9_perr", int'(perr_o), int'(exp_perr));
    chk("t9_ferr", int'(ferr_o), int'(exp_ferr));
    chk("t9_ovf", int'(ovf_o), int'(exp_ovf));
    chk("t9_irq", int'(irq_o), int'(exp_perr | exp_ferr | exp_ovf));
    chk("t9_empty", int'(valid_o), 0);
    chk("t9_model_empty", model_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
